// File: rtl/mem_stage.sv
// LC-3b memory-access stage: word, byte and indirect data-memory
// transactions over a request/response handshake, with pipeline stall.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        indirect_in,
    input  logic        byte_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] sr_data_in,
    input  logic        advance_in,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] mem_wdata_out,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, IND, ACC, DONE} state_t;

    state_t      state;
    logic [15:0] ptr;
    logic        pending;
    logic        byte_op;
    logic [15:0] acc_addr;
    logic [7:0]  sel_byte;
    logic [15:0] load_val;

    assign pending = valid_in & (mem_read_in | mem_write_in);
    // Indirect wins over byte when both are set.
    assign byte_op = byte_in & ~indirect_in;

    always_comb begin
        acc_addr = {addr_in[15:1], 1'b0};
        if (indirect_in)
            acc_addr = {ptr[15:1], 1'b0};
        else if (byte_op)
            acc_addr = addr_in;
    end

    assign sel_byte = acc_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    assign load_val = byte_op ? {{8{sel_byte[7]}}, sel_byte} : dmem_rdata;

    assign stall = ((state == IDLE) & pending) | (state == IND) | (state == ACC);

    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        unique case (state)
            IND: begin
                dmem_read        = 1'b1;
                dmem_address     = {addr_in[15:1], 1'b0};
                dmem_byte_enable = 2'b11;
            end
            ACC: begin
                dmem_address = acc_addr;
                if (mem_read_in) begin
                    dmem_read        = 1'b1;
                    dmem_byte_enable = 2'b11;
                end else if (byte_op) begin
                    dmem_write       = 1'b1;
                    dmem_wdata       = {sr_data_in[7:0], sr_data_in[7:0]};
                    dmem_byte_enable = acc_addr[0] ? 2'b10 : 2'b01;
                end else begin
                    dmem_write       = 1'b1;
                    dmem_wdata       = sr_data_in;
                    dmem_byte_enable = 2'b11;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 16'h0000;
            mem_wdata_out <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending)
                        state <= indirect_in ? IND : ACC;
                end
                IND: begin
                    if (dmem_resp) begin
                        ptr   <= dmem_rdata;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (dmem_resp) begin
                        if (mem_read_in)
                            mem_wdata_out <= load_val;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (advance_in)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// A small responder answers requests after a chosen number of cycles.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        indirect_in;
    logic        byte_in;
    logic [15:0] addr_in;
    logic [15:0] sr_data_in;
    logic        advance_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] mem_wdata_out;
    logic        stall;

    int errors = 0;
    int checks = 0;
    int stall_cnt;
    logic [15:0] q_addr [2];
    logic [15:0] q_wd   [2];
    logic [1:0]  q_be   [2];
    logic        q_rd   [2];
    logic        q_wr   [2];

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .indirect_in      (indirect_in),
        .byte_in          (byte_in),
        .addr_in          (addr_in),
        .sr_data_in       (sr_data_in),
        .advance_in       (advance_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_wdata_out    (mem_wdata_out),
        .stall            (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic ind,
                          input logic byt, input logic [15:0] a,
                          input logic [15:0] sr);
        valid_in     = 1'b1;
        mem_read_in  = rd;
        mem_write_in = wr;
        indirect_in  = ind;
        byte_in      = byt;
        addr_in      = a;
        sr_data_in   = sr;
        advance_in   = 1'b0;
    endtask

    // Runs one memory instruction until stall drops (first DONE cycle).
    task automatic do_access(input int lat, input logic [15:0] r0,
                             input logic [15:0] r1);
        int wc;
        int idx;
        int cyc;
        wc = 0;
        idx = 0;
        cyc = 0;
        stall_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            q_addr[k] = 16'h0;
            q_wd[k]   = 16'h0;
            q_be[k]   = 2'b0;
            q_rd[k]   = 1'b0;
            q_wr[k]   = 1'b0;
        end
        #1;
        forever begin
            if ((dmem_read | dmem_write) && idx < 2) begin
                if (wc == 0) begin
                    q_addr[idx] = dmem_address;
                    q_wd[idx]   = dmem_wdata;
                    q_be[idx]   = dmem_byte_enable;
                    q_rd[idx]   = dmem_read;
                    q_wr[idx]   = dmem_write;
                end else begin
                    check("hold_addr", dmem_address, q_addr[idx]);
                end
                wc++;
                if (wc == lat) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = (idx == 0) ? r0 : r1;
                    idx++;
                    wc = 0;
                end
            end
            if (!stall)
                break;
            stall_cnt++;
            step();
            dmem_resp  = 1'b0;
            dmem_rdata = 16'hDEAD;
            cyc++;
            if (cyc > 30) begin
                check("timeout", cyc, 30);
                break;
            end
        end
    endtask

    task automatic retire();
        advance_in = 1'b1;
        step();
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        indirect_in  = 1'b0;
        byte_in      = 1'b0;
        advance_in   = 1'b0;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        valid_in     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        indirect_in  = 1'b0;
        byte_in      = 1'b0;
        addr_in      = 16'h0;
        sr_data_in   = 16'h0;
        advance_in   = 1'b0;
        dmem_resp    = 1'b0;
        dmem_rdata   = 16'hDEAD;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_read", dmem_read, 1'b0);
        check("rst_write", dmem_write, 1'b0);
        check("rst_addr", dmem_address, 16'h0);
        check("rst_wdata", dmem_wdata, 16'h0);
        check("rst_be", dmem_byte_enable, 2'b00);
        check("rst_out", mem_wdata_out, 16'h0);
        check("rst_stall", stall, 1'b0);
        step();

        // LDR
        set_op(1, 0, 0, 0, 16'h3001, 16'h0);
        do_access(1, 16'hBEEF, 16'h0);
        check("ldr_addr", q_addr[0], 16'h3000);
        check("ldr_be", q_be[0], 2'b11);
        check("ldr_rd", q_rd[0], 1'b1);
        check("ldr_stall", stall_cnt, 2);
        check("ldr_out", mem_wdata_out, 16'hBEEF);
        retire();

        // LDB odd / even
        set_op(1, 0, 0, 1, 16'h2005, 16'h0);
        do_access(1, 16'h80FF, 16'h0);
        check("ldb_odd_addr", q_addr[0], 16'h2005);
        check("ldb_odd_out", mem_wdata_out, 16'hFF80);
        retire();
        set_op(1, 0, 0, 1, 16'h2004, 16'h0);
        do_access(1, 16'h80FF, 16'h0);
        check("ldb_even_out", mem_wdata_out, 16'hFFFF);
        retire();

        // STB odd
        set_op(0, 1, 0, 1, 16'h1003, 16'h1234);
        do_access(1, 16'h0, 16'h0);
        check("stb_wr", q_wr[0], 1'b1);
        check("stb_wdata", q_wd[0], 16'h3434);
        check("stb_be", q_be[0], 2'b10);
        check("stb_addr", q_addr[0], 16'h1003);
        check("stb_out", mem_wdata_out, 16'hFFFF);
        retire();

        // LDI, then hold in DONE
        set_op(1, 0, 1, 0, 16'h4000, 16'h0);
        do_access(1, 16'h5003, 16'h00AA);
        check("ldi_addr0", q_addr[0], 16'h4000);
        check("ldi_addr1", q_addr[1], 16'h5002);
        check("ldi_stall", stall_cnt, 3);
        check("ldi_out", mem_wdata_out, 16'h00AA);
        for (int i = 0; i < 3; i++) begin
            step();
            check("done_req", {dmem_read, dmem_write}, 2'b00);
            check("done_stall", stall, 1'b0);
            check("done_out", mem_wdata_out, 16'h00AA);
        end
        retire();

        // STI with 2-cycle memory
        set_op(0, 1, 1, 0, 16'h6000, 16'hABCD);
        do_access(2, 16'h7005, 16'h0);
        check("sti_addr0", q_addr[0], 16'h6000);
        check("sti_rd0", q_rd[0], 1'b1);
        check("sti_addr1", q_addr[1], 16'h7004);
        check("sti_wr1", q_wr[1], 1'b1);
        check("sti_wdata", q_wd[1], 16'hABCD);
        check("sti_be", q_be[1], 2'b11);
        check("sti_stall", stall_cnt, 5);
        check("sti_out", mem_wdata_out, 16'h00AA);
        retire();

        // Non-memory instruction
        set_op(0, 0, 0, 0, 16'h1234, 16'h0);
        #1;
        check("nop_stall", stall, 1'b0);
        step();
        check("nop_req", {dmem_read, dmem_write}, 2'b00);
        check("nop_stall2", stall, 1'b0);
        valid_in = 1'b0;
        step();

        // Reset mid-ACC
        set_op(1, 0, 0, 0, 16'h3001, 16'h0);
        step();
        check("racc_read", dmem_read, 1'b1);
        reset = 1'b1;
        step();
        check("racc_read0", dmem_read, 1'b0);
        check("racc_addr", dmem_address, 16'h0);
        check("racc_out", mem_wdata_out, 16'h0);
        valid_in = 1'b0;
        reset = 1'b0;
        dmem_resp = 1'b1;
        dmem_rdata = 16'h5555;
        step();
        dmem_resp = 1'b0;
        step();
        check("racc_ignore", mem_wdata_out, 16'h0);
        check("racc_idle", {dmem_read, dmem_write, stall}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
